// File: rtl/attention_pkg.sv
// Shared constants and types for the attention score engine.
//   LANES/ELEM_W     : int8 lanes per 512-bit RAM row
//   SCORE_W          : width of one signed dot-product score
//   SCORES_PER_WORD  : scores packed into one output word
//   state_e          : score-engine control FSM states
package attention_pkg;

   localparam int unsigned LANES           = 64;
   localparam int unsigned ELEM_W          = 8;
   localparam int unsigned PROD_W          = 2 * ELEM_W;
   localparam int unsigned SCORE_W         = 32;
   localparam int unsigned SCORES_PER_WORD = 16;
   localparam int unsigned LANE_SEL_W      = $clog2(SCORES_PER_WORD);
   localparam int unsigned ADDR_W          = 12;
   localparam int unsigned WORD_W          = 512;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StDrain,
      StDone
   } state_e;

endpackage

// File: rtl/attention_if.sv
// RAM read ports and output-buffer write port of the score engine.
//   dina/dinb   : Q/K row data, registered one cycle after addra/addrb
//   addra/addrb : Q/K row read addresses
//   addrc/doutc : output word address and packed scores
// master = score engine, slave = RAM / output buffer side.
interface attention_if;

   logic [attention_pkg::WORD_W-1:0] dina;
   logic [attention_pkg::WORD_W-1:0] dinb;
   logic [attention_pkg::ADDR_W-1:0] addra;
   logic [attention_pkg::ADDR_W-1:0] addrb;
   logic [attention_pkg::ADDR_W-1:0] addrc;
   logic [attention_pkg::WORD_W-1:0] doutc;

   modport master (
      input  dina, dinb,
      output addra, addrb, addrc, doutc
   );

   modport slave (
      output dina, dinb,
      input  addra, addrb, addrc, doutc
   );

endinterface

// File: rtl/attention_dot_product_64.sv
// 64-lane signed int8 dot product with a fixed two-cycle latency.
//   clk, rst_n : clock, asynchronous active-low reset
//   a_i, b_i   : 64 packed signed int8 lanes each (lane k = bits [8k+7:8k])
//   sum_o      : registered 32-bit signed sum of the 64 lane products
// Cycle 1 registers the products, cycle 2 registers their sum.
module attention_dot_product_64
   import attention_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [WORD_W-1:0]         a_i,
   input  logic [WORD_W-1:0]         b_i,
   output logic signed [SCORE_W-1:0] sum_o
);

   logic signed [PROD_W-1:0]  prod_d [LANES];
   logic signed [PROD_W-1:0]  prod_q [LANES];
   logic signed [SCORE_W-1:0] sum_d;
   logic signed [SCORE_W-1:0] sum_q;

   always_comb begin
      for (int k = 0; k < LANES; k++) begin
         prod_d[k] = PROD_W'($signed(a_i[ELEM_W*k +: ELEM_W]))
                   * PROD_W'($signed(b_i[ELEM_W*k +: ELEM_W]));
      end
   end

   // Plain accumulation; synthesis balances it into an adder tree. Max |sum| is 2^20.
   always_comb begin
      sum_d = '0;
      for (int k = 0; k < LANES; k++) begin
         sum_d = sum_d + SCORE_W'(prod_q[k]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < LANES; k++) begin
            prod_q[k] <= '0;
         end
         sum_q <= '0;
      end else begin
         for (int k = 0; k < LANES; k++) begin
            prod_q[k] <= prod_d[k];
         end
         sum_q <= sum_d;
      end
   end

   assign sum_o = sum_q;

endmodule

// File: rtl/attention_top_core.sv
// Score engine: streams Q rows (port A) and K rows (port B) from a synchronous word RAM,
// computes S = Q*K^T as signed int8 dot products and writes 16 packed 32-bit scores per
// output word. Runs one full pass after reset release, then idles until the next reset.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : attention_if master (dina/dinb in; addra/addrb/addrc/doutc out)
// Pipeline for a pair issued in cycle t: RAM data t+1, products t+2, sum t+3,
// pack/output t+4.
module attention_top_core
   import attention_pkg::*;
#(
   parameter int unsigned SEQ_LEN  = 64,
   parameter int unsigned Q_BASE   = 0,
   parameter int unsigned K_BASE   = 64,
   parameter int unsigned OUT_BASE = 0
) (
   input logic         clk,
   input logic         rst_n,
   attention_if.master bus
);

   localparam int unsigned IdxW        = $clog2(SEQ_LEN);
   localparam int unsigned WordsPerRow = SEQ_LEN / SCORES_PER_WORD;
   localparam logic [1:0]  DrainLast   = 2'd3;

   typedef logic [IdxW-1:0] idx_t;
   typedef logic [SCORES_PER_WORD-1:0][SCORE_W-1:0] pack_t;

   localparam idx_t IdxLast = idx_t'(SEQ_LEN - 1);

   state_e state_q, state_d;

   idx_t              i_q, i_d, j_q, j_d;
   logic [ADDR_W-1:0] addra_q, addra_d, addrb_q, addrb_d;
   logic [1:0]        drain_q, drain_d;

   logic start, issue, drain_en, last_pair;

   // Tag pipeline: which (i,j) the data at each stage belongs to.
   logic v1_q, v2_q, v3_q;
   idx_t i1_q, i2_q, i3_q, j1_q, j2_q, j3_q;

   logic signed [SCORE_W-1:0] sum;
   logic [LANE_SEL_W-1:0]     lane;

   pack_t             pack_q, pack_d;
   logic [WORD_W-1:0] doutc_q, doutc_d;
   logic [ADDR_W-1:0] addrc_q, addrc_d;

   assign last_pair = (i_q == IdxLast) && (j_q == IdxLast);

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  state_d = StIssue;
         StIssue: if (last_pair) state_d = StDrain;
         StDrain: if (drain_q == DrainLast) state_d = StDone;
         StDone:  state_d = StDone;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      start    = (state_q == StIdle);
      issue    = (state_q == StIssue);
      drain_en = (state_q == StDrain);
   end

   // ---------------- counters and addresses ----------------
   // Addresses are registered so they show the pair being issued during ISSUE cycles;
   // the first pair is loaded on the IDLE -> ISSUE edge.
   always_comb begin
      i_d     = i_q;
      j_d     = j_q;
      addra_d = addra_q;
      addrb_d = addrb_q;
      drain_d = drain_q;
      if (start) begin
         i_d     = '0;
         j_d     = '0;
         addra_d = ADDR_W'(Q_BASE);
         addrb_d = ADDR_W'(K_BASE);
      end else if (issue && !last_pair) begin
         if (j_q == IdxLast) begin
            j_d = '0;
            i_d = i_q + 1'b1;
         end else begin
            j_d = j_q + 1'b1;
         end
         addra_d = ADDR_W'(Q_BASE) + ADDR_W'(i_d);
         addrb_d = ADDR_W'(K_BASE) + ADDR_W'(j_d);
      end
      if (drain_en) begin
         drain_d = drain_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         i_q     <= '0;
         j_q     <= '0;
         addra_q <= '0;
         addrb_q <= '0;
         drain_q <= '0;
      end else begin
         i_q     <= i_d;
         j_q     <= j_d;
         addra_q <= addra_d;
         addrb_q <= addrb_d;
         drain_q <= drain_d;
      end
   end

   // ---------------- datapath ----------------
   attention_dot_product_64 u_dot (
      .clk   (clk),
      .rst_n (rst_n),
      .a_i   (bus.dina),
      .b_i   (bus.dinb),
      .sum_o (sum)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q <= 1'b0;
         v2_q <= 1'b0;
         v3_q <= 1'b0;
         i1_q <= '0;
         i2_q <= '0;
         i3_q <= '0;
         j1_q <= '0;
         j2_q <= '0;
         j3_q <= '0;
      end else begin
         v1_q <= issue;
         v2_q <= v1_q;
         v3_q <= v2_q;
         i1_q <= i_q;
         i2_q <= i1_q;
         i3_q <= i2_q;
         j1_q <= j_q;
         j2_q <= j1_q;
         j3_q <= j2_q;
      end
   end

   assign lane = j3_q[LANE_SEL_W-1:0];

   // The last lane goes straight into doutc together with the 15 already packed.
   always_comb begin
      pack_d  = pack_q;
      doutc_d = doutc_q;
      addrc_d = addrc_q;
      if (v3_q) begin
         pack_d[lane] = sum;
         if (lane == LANE_SEL_W'(SCORES_PER_WORD - 1)) begin
            doutc_d = pack_d;
            addrc_d = ADDR_W'(OUT_BASE) + ADDR_W'(i3_q) * ADDR_W'(WordsPerRow)
                    + ADDR_W'(j3_q >> LANE_SEL_W);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pack_q  <= '0;
         doutc_q <= '0;
         addrc_q <= '1;  // all-ones: no word delivered yet
      end else begin
         pack_q  <= pack_d;
         doutc_q <= doutc_d;
         addrc_q <= addrc_d;
      end
   end

   assign bus.addra = addra_q;
   assign bus.addrb = addrb_q;
   assign bus.addrc = addrc_q;
   assign bus.doutc = doutc_q;

endmodule

// File: tb/tb_attention_top_core.sv
// Bench for attention_top_core: synchronous RAM model, output log on addrc changes,
// score matrix computed directly as Q*K^T from the row bytes.
module tb_attention_top_core;
   import attention_pkg::*;

   localparam int SEQ    = 64;
   localparam int QB     = 0;
   localparam int KB     = 64;
   localparam int NWORDS = SEQ * SEQ / 16;

   typedef logic [WORD_W-1:0] word_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   always #5 clk = ~clk;

   attention_if bus ();

   attention_top_core #(
      .SEQ_LEN  (SEQ),
      .Q_BASE   (QB),
      .K_BASE   (KB),
      .OUT_BASE (0)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   word_t mem [4096];

   always @(posedge clk) begin
      bus.dina <= mem[bus.addra];
      bus.dinb <= mem[bus.addrb];
   end

   byte q [SEQ][SEQ];
   byte k [SEQ][SEQ];
   int  score [SEQ][SEQ];

   int total = 0;
   int bad   = 0;

   int          cyc;
   bit          seen_issue;
   int          issue_cyc;
   logic [11:0] prev_addrc;
   logic [11:0] got_addr [$];
   word_t       got_word [$];
   int          got_cyc  [$];

   task automatic check_eq(input string tag, input word_t got, input word_t exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One cycle: sample on the falling edge, log first issue and every addrc change.
   task automatic step();
      @(negedge clk);
      cyc++;
      if (!seen_issue && bus.addrb == 12'(KB)) begin
         seen_issue = 1'b1;
         issue_cyc  = cyc;
      end
      if (bus.addrc != prev_addrc) begin
         got_addr.push_back(bus.addrc);
         got_word.push_back(bus.doutc);
         got_cyc.push_back(cyc);
         prev_addrc = bus.addrc;
      end
   endtask

   task automatic fill(input int mode);
      for (int i = 0; i < SEQ; i++) begin
         for (int l = 0; l < SEQ; l++) begin
            case (mode)
               0:       begin q[i][l] = 8'sh01; k[i][l] = 8'sh01; end
               1:       begin q[i][l] = -8'sd1; k[i][l] = 8'sh02; end
               2:       begin q[i][l] = -8'sd128; k[i][l] = -8'sd128; end
               3:       begin
                  q[i][l] = (l == i % 64) ? 8'sh01 : 8'sh00;
                  k[i][l] = (l == i % 64) ? 8'sh05 : 8'sh00;
               end
               default: begin q[i][l] = byte'($urandom); k[i][l] = byte'($urandom); end
            endcase
         end
      end
      for (int i = 0; i < SEQ; i++) begin
         for (int l = 0; l < SEQ; l++) begin
            mem[QB + i][8*l +: 8] = q[i][l];
            mem[KB + i][8*l +: 8] = k[i][l];
         end
      end
      for (int i = 0; i < SEQ; i++) begin
         for (int j = 0; j < SEQ; j++) begin
            score[i][j] = 0;
            for (int l = 0; l < SEQ; l++) begin
               score[i][j] += int'(q[i][l]) * int'(k[j][l]);
            end
         end
      end
   endtask

   function automatic word_t exp_word(input int w);
      word_t r;
      int    row = w / (SEQ / 16);
      int    jb  = (w % (SEQ / 16)) * 16;
      for (int m = 0; m < 16; m++) begin
         r[32*m +: 32] = score[row][jb + m];
      end
      return r;
   endfunction

   task automatic start_pass();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      got_addr.delete();
      got_word.delete();
      got_cyc.delete();
      seen_issue = 1'b0;
      issue_cyc  = 0;
      cyc        = 0;
      prev_addrc = 12'hFFF;
      rst_n = 1'b1;
   endtask

   task automatic run_pass(input string name, input bit has_const, input logic [31:0] lc);
      int n;
      int n_words;
      start_pass();
      n = 0;
      while (got_addr.size() < NWORDS && n < SEQ * SEQ + 200) begin
         step();
         n++;
      end
      n_words = got_addr.size();
      check_eq({name, ":words"}, word_t'(n_words), word_t'(NWORDS));
      check_eq({name, ":issue_seen"}, word_t'(seen_issue), word_t'(1));
      if (n_words > 0) begin
         check_eq({name, ":first_lat"}, word_t'(got_cyc[0] - issue_cyc), word_t'(19));
      end
      if (n_words == NWORDS) begin
         check_eq({name, ":last_lat"}, word_t'(got_cyc[NWORDS-1] - issue_cyc),
                  word_t'(SEQ * SEQ + 3));
      end
      repeat (100) step();
      check_eq({name, ":quiet"}, word_t'(got_addr.size()), word_t'(n_words));
      check_eq({name, ":addra_hold"}, word_t'(bus.addra), word_t'(QB + SEQ - 1));
      check_eq({name, ":addrb_hold"}, word_t'(bus.addrb), word_t'(KB + SEQ - 1));
      for (int w = 0; w < n_words && w < NWORDS; w++) begin
         check_eq($sformatf("%s:addrc[%0d]", name, w), word_t'(got_addr[w]), word_t'(w));
         check_eq($sformatf("%s:doutc[%0d]", name, w), got_word[w], exp_word(w));
      end
      if (has_const && n_words > 0) begin
         check_eq({name, ":const_first"}, got_word[0], {16{lc}});
         check_eq({name, ":const_last"}, got_word[n_words-1], {16{lc}});
      end
   endtask

   initial begin
      bus.dina   = '0;
      bus.dinb   = '0;
      cyc        = 0;
      seen_issue = 1'b0;
      issue_cyc  = 0;
      prev_addrc = 12'hFFF;
      #2 rst_n = 1'b0;
      #1;
      check_eq("rst:addra", word_t'(bus.addra), word_t'(0));
      check_eq("rst:addrb", word_t'(bus.addrb), word_t'(0));
      check_eq("rst:addrc", word_t'(bus.addrc), word_t'(12'hFFF));
      check_eq("rst:doutc", bus.doutc, word_t'(0));

      fill(0);
      run_pass("ones", 1'b1, 32'h0000_0040);
      fill(1);
      run_pass("neg", 1'b1, 32'hFFFF_FF80);
      fill(2);
      run_pass("min", 1'b1, 32'h0010_0000);
      fill(3);
      run_pass("onehot", 1'b0, 32'h0);
      fill(4);
      run_pass("rand", 1'b0, 32'h0);

      // Reset in the middle of a pass, then a full pass must reproduce the same words.
      start_pass();
      repeat (1000) step();
      check_eq("midrst:had_words", word_t'(got_addr.size() > 20), word_t'(1));
      rst_n = 1'b0;
      #1;
      check_eq("midrst:addrc", word_t'(bus.addrc), word_t'(12'hFFF));
      check_eq("midrst:doutc", bus.doutc, word_t'(0));
      check_eq("midrst:addra", word_t'(bus.addra), word_t'(0));
      check_eq("midrst:addrb", word_t'(bus.addrb), word_t'(0));
      run_pass("rerun", 1'b0, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
